// File: rtl/encoder_8to3_pending_pkg.sv
// Shared types and constants for the 8-to-3 pending encoder.
// The priority helper returns the index of the highest set bit, or 0 when none is set.
package encoder_8to3_pending_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // The last matching index wins, so bit 7 has the highest priority.
  function automatic logic [CODE_W-1:0] prio_index(input logic [NUM_REQ-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder_8to3_pending_sync_bus.sv
// Per-bit multi-flop synchroniser for a bus of asynchronous level inputs.
// Each bit is independent; no coherency is implied across the bus.
module encoder_8to3_pending_sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/encoder_8to3_pending.sv
// Sequential 8-to-3 encoder: synchronised rising edges become sticky pending bits,
// granted highest-index first as a registered code with a valid/ready handshake.
module encoder_8to3_pending
  import encoder_8to3_pending_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NUM_REQ-1:0] o_pending
);

  logic [NUM_REQ-1:0] w_sync;
  logic [NUM_REQ-1:0] r_hist;
  logic [NUM_REQ-1:0] w_rise;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [NUM_REQ-1:0] w_clr;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  w_code_nxt;
  state_e             r_state;
  state_e             w_state_nxt;

  encoder_8to3_pending_sync_bus #(
    .WIDTH  (NUM_REQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_req),
    .o_q   (w_sync)
  );

  // History keeps tracking while disabled so a level held across enable=0 never re-fires.
  assign w_rise = w_sync & ~r_hist;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (r_pending != '0)) begin
          w_code_nxt  = prio_index(r_pending);
          w_clr       = NUM_REQ'(1) << w_code_nxt;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_ready) w_state_nxt = ST_IDLE;
      end
    endcase
    // OR-ing the rise after the clear lets a same-cycle set win.
    w_pending_nxt = (r_pending & ~w_clr) | (i_enable ? w_rise : '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist    <= '0;
      r_pending <= '0;
      r_code    <= '0;
      r_state   <= ST_IDLE;
    end else begin
      r_hist    <= w_sync;
      r_pending <= w_pending_nxt;
      r_code    <= w_code_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign o_code    = r_code;
  assign o_valid   = (r_state == ST_HOLD);
  assign o_pending = r_pending;

endmodule

// File: tb/tb_encoder_8to3_pending.sv
// Directed self-checking bench for encoder_8to3_pending.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_encoder_8to3_pending;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       enable;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  encoder_8to3_pending #(.SYNC_STAGES(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_enable  (enable),
    .o_code    (code),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    req = 8'h00;
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; enable = 1'b1; ready = 1'b0;
    repeat (2) step();
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (code !== 3'd0) $display("FAIL reset_code: got %0d want 0", code); else n_pass++;
    n_checks++; if (pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", pending); else n_pass++;
    rst = 1'b0;
    repeat (4) step();
    n_checks++; if (valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_single();
    ready = 1'b1; enable = 1'b1;
    req = 8'h20;                 // rises before edge 0
    step(); step(); step();      // edges 0..2
    n_checks++; if (pending !== 8'h20) $display("FAIL single_pending_set: got %h want 20", pending); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL single_valid_early: got %b want 0", valid); else n_pass++;
    step();                      // edge 3
    n_checks++; if (valid !== 1'b1) $display("FAIL single_valid: got %b want 1", valid); else n_pass++;
    n_checks++; if (code !== 3'd5) $display("FAIL single_code: got %0d want 5", code); else n_pass++;
    n_checks++; if (pending !== 8'h00) $display("FAIL single_pending_clr: got %h want 00", pending); else n_pass++;
    step();                      // edge 4
    n_checks++; if (valid !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", valid); else n_pass++;
    settle();
  endtask

  task automatic test_priority();
    ready = 1'b0; enable = 1'b1;
    req = 8'h81;
    repeat (4) step();           // edges 0..3
    n_checks++; if (code !== 3'd7 || valid !== 1'b1)
      $display("FAIL prio_first: got code=%0d valid=%b want code=7 valid=1", code, valid); else n_pass++;
    n_checks++; if (pending !== 8'h01) $display("FAIL prio_pending: got %h want 01", pending); else n_pass++;
    repeat (3) step();
    n_checks++; if (code !== 3'd7 || valid !== 1'b1)
      $display("FAIL prio_hold: got code=%0d valid=%b want code=7 valid=1", code, valid); else n_pass++;
    ready = 1'b1;
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL prio_idle_gap: got %b want 0", valid); else n_pass++;
    step();
    n_checks++; if (code !== 3'd0 || valid !== 1'b1)
      $display("FAIL prio_second: got code=%0d valid=%b want code=0 valid=1", code, valid); else n_pass++;
    n_checks++; if (pending !== 8'h00) $display("FAIL prio_drained: got %h want 00", pending); else n_pass++;
    step();
    ready = 1'b0;
    settle();
  endtask

  task automatic test_set_wins();
    ready = 1'b0; enable = 1'b1;
    req = 8'h88;
    repeat (4) step();           // edges 0..3: grant 7, bit 3 left pending
    n_checks++; if (code !== 3'd7 || pending !== 8'h08)
      $display("FAIL setwin_setup: got code=%0d pending=%h want code=7 pending=08", code, pending); else n_pass++;
    req = 8'h80;                 // req[3] low before edge 4
    step();
    req = 8'h88;                 // req[3] rises before edge 5, reaches pending at edge 7
    step();
    ready = 1'b1;
    step();                      // edge 6: HOLD -> IDLE
    n_checks++; if (valid !== 1'b0 || pending !== 8'h08)
      $display("FAIL setwin_idle: got valid=%b pending=%h want valid=0 pending=08", valid, pending); else n_pass++;
    ready = 1'b0;
    step();                      // edge 7: grant 3 and rise 3 together
    n_checks++; if (code !== 3'd3 || valid !== 1'b1)
      $display("FAIL setwin_grant: got code=%0d valid=%b want code=3 valid=1", code, valid); else n_pass++;
    n_checks++; if (pending !== 8'h08) $display("FAIL setwin_sticky: got %h want 08", pending); else n_pass++;
    ready = 1'b1;
    step();
    step();
    n_checks++; if (code !== 3'd3 || valid !== 1'b1 || pending !== 8'h00)
      $display("FAIL setwin_regrant: got code=%0d valid=%b pending=%h want 3/1/00", code, valid, pending); else n_pass++;
    step();
    ready = 1'b0;
    settle();
  endtask

  task automatic test_level_enable();
    int nv;
    logic [2:0] seen;
    ready = 1'b1; enable = 1'b1;
    req = 8'h02;
    nv = 0; seen = 3'd0;
    repeat (20) begin
      step();
      if (valid === 1'b1) begin nv++; seen = code; end
    end
    n_checks++; if (nv != 1) $display("FAIL level_grants: got %0d want 1", nv); else n_pass++;
    n_checks++; if (seen !== 3'd1) $display("FAIL level_code: got %0d want 1", seen); else n_pass++;
    settle();

    enable = 1'b0;
    req = 8'h10;
    nv = 0;
    repeat (6) begin step(); if (valid === 1'b1) nv++; end
    n_checks++; if (nv != 0) $display("FAIL dis_grants: got %0d want 0", nv); else n_pass++;
    n_checks++; if (pending !== 8'h00) $display("FAIL dis_pending: got %h want 00", pending); else n_pass++;
    enable = 1'b1;
    repeat (4) begin step(); if (valid === 1'b1) nv++; end
    n_checks++; if (nv != 0 || pending !== 8'h00)
      $display("FAIL dis_no_late_rise: got grants=%0d pending=%h want 0/00", nv, pending); else n_pass++;
    settle();

    req = 8'h40;
    step(); step(); step();      // pending[6] set at edge 2
    enable = 1'b0;
    n_checks++; if (pending !== 8'h40) $display("FAIL retain_set: got %h want 40", pending); else n_pass++;
    nv = 0;
    repeat (5) begin step(); if (valid === 1'b1) nv++; end
    n_checks++; if (nv != 0 || pending !== 8'h40)
      $display("FAIL retain_held: got grants=%0d pending=%h want 0/40", nv, pending); else n_pass++;
    enable = 1'b1;
    step();
    n_checks++; if (valid !== 1'b1 || code !== 3'd6 || pending !== 8'h00)
      $display("FAIL retain_grant: got valid=%b code=%0d pending=%h want 1/6/00", valid, code, pending); else n_pass++;
    step();
    settle();
  endtask

  task automatic test_all_bits();
    logic [2:0] exp_code;
    ready = 1'b1; enable = 1'b1;
    req = 8'hFF;
    step(); step(); step();
    n_checks++; if (pending !== 8'hFF) $display("FAIL all_pending: got %h want FF", pending); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_code = 3'(7 - i);
      step();
      n_checks++; if (valid !== 1'b1 || code !== exp_code)
        $display("FAIL all_grant%0d: got valid=%b code=%0d want 1/%0d", i, valid, code, exp_code); else n_pass++;
      step();
      n_checks++; if (valid !== 1'b0) $display("FAIL all_gap%0d: got %b want 0", i, valid); else n_pass++;
    end
    n_checks++; if (pending !== 8'h00) $display("FAIL all_drained: got %h want 00", pending); else n_pass++;
    settle();
  endtask

  task automatic test_reset_mid_hold();
    int nv;
    ready = 1'b0; enable = 1'b1;
    req = 8'h05;
    repeat (4) step();
    n_checks++; if (valid !== 1'b1 || code !== 3'd2 || pending !== 8'h01)
      $display("FAIL rsthold_setup: got valid=%b code=%0d pending=%h want 1/2/01", valid, code, pending); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00)
      $display("FAIL rsthold_async: got valid=%b code=%0d pending=%h want 0/0/00", valid, code, pending); else n_pass++;
    req = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    ready = 1'b1;
    nv = 0;
    repeat (8) begin step(); if (valid === 1'b1) nv++; end
    n_checks++; if (nv != 0 || pending !== 8'h00)
      $display("FAIL rsthold_quiet: got grants=%0d pending=%h want 0/00", nv, pending); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_set_wins();
    test_level_enable();
    test_all_bits();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder_8to3_pending.md
Name: encoder_8to3_pending

Overview:
- Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decoder: turns eight asynchronous request lines into a 3-bit code with a valid/ready handshake.
- Synchronises the inputs, captures rising edges into a sticky pending register, then presents the highest-index pending request as a registered code.
- Feeds the decoder path: its code/valid pair drives a[2:0]/enable of a downstream decoder or any code consumer.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser chain; legal range ≥2.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  asynchronous request lines, level; a rising edge raises a request.
- enable  input  1  capture/grant enable.
- code  output  3  encoded index of the granted request.
- valid  output  1  code holds a granted request.
- ready  input  1  consumer accepts code when valid && ready at a clk edge.
- pending  output  8  sticky pending requests not yet granted (status).

Behaviour:
- Reset (async assert, sync release): sync chains, edge-detect history, pending, code are 0; valid=0; state IDLE.
- Synchroniser: req passes through SYNC_STAGES flops to give s[7:0]. The history register h<=s. rise = s & ~h (combinational).
- Pending update each edge: pending <= (pending & ~clr) | (enable ? rise : 0).
  - clr is the one-hot of the bit granted this cycle.
  - Set wins: a rise on the bit being cleared in the same cycle leaves it set.
- A held-high req raises exactly one request. Re-arming needs a low-then-high transition.
- FSM states:
  - IDLE: valid=0. If enable && pending!=0, then on the next edge: code <= index of the highest set pending bit (bit 7 highest priority); clear that bit; valid<=1; go to HOLD.
  - HOLD: valid=1 and code stable. On valid && ready: valid<=0 and go to IDLE. There is no back-to-back grant; at least one IDLE cycle sits between grants.
- Latency: if req rises before edge k and is stable, s rises after edge k+SYNC_STAGES-1, pending sets after edge k+SYNC_STAGES, and valid rises after edge k+SYNC_STAGES+1 (k+3 for default). This assumes IDLE and enable=1.
- enable=0 behaviour:
  - New rises are ignored (not queued); h still tracks s.
  - No new grant is made; existing pending bits are retained.
  - An in-flight HOLD still completes on ready.
- Boundary cases:
  - Several rises in one cycle: all are captured, then granted highest-first on successive grants.
  - All 8 pending: granted in order 7,6,...,0.
  - ready held high permanently: each grant lasts exactly one cycle of valid.
  - ready high while valid=0: no effect.
- Reset mid-HOLD: valid drops immediately (asynchronously); pending is lost.
- code width: always 3 bits. Bits 0..7 map to code 3'd0..3'd7 exactly as the decoder's a input.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, HOLD=1'b1), NUM_REQ=8, CODE_W=3.
- Sub-module sync_bus: SYNC_STAGES-deep per-bit synchroniser, width parameter, async reset. It is reusable by other input blocks.
- Priority encode and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-HOLD -> valid=0, code=0, pending=8'h00 immediately; no grant until req edges occur after release.
- Single request: req=8'h20 rises before edge 0, ready=1 -> valid=1 with code=3'd5 after edge 3 for exactly one cycle; pending=8'h00 afterwards.
- Priority and queueing: req goes 0 to 8'h81 in one cycle, ready=0 -> code=7, valid held. Pulse ready, then after the IDLE cycle code=0.
- Set-wins collision: req[3] toggles so that its rise reaches pending on the same edge bit 3 is granted -> pending[3] stays 1 and a second grant with code=3 follows.
- Level hold and enable: req=8'h02 held high for 20 cycles -> exactly one grant. With enable=0, a rise on req[4] -> no grant, pending[4]=0. With enable=0 and pending[6] set -> no grant until enable returns to 1.
- All bits: req=8'hFF in one step, ready=1 -> codes 7,6,5,4,3,2,1,0 in order, each grant separated by one IDLE cycle; pending returns to 8'h00.
